// File: rtl/arb_pkg.sv
// Shared definitions for the grant-mux side of the arbiter_priority subsystem.
// Provides the channel-ownership state encoding, a ceiling-log2 helper used to
// size master index fields, and a one-hot decoder for master indices.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Upper bound on master count supported by the one-hot helper.
  localparam int ARB_MAXW = 32;

  // Ceiling log2, never less than 1 so a single-master build still gets an
  // index bit.
  function automatic int arb_log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index to one-hot; an index at or beyond ARB_MAXW yields all zeros, which
  // callers rely on to discard out-of-range grants.
  function automatic logic [ARB_MAXW-1:0] arb_onehot(input int unsigned idx);
    logic [ARB_MAXW-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < ARB_MAXW; i++) begin
      if (idx == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/arb_payload_mux.sv
// Combinational WIDTH:1 selector of the owning master's {valid, data, last}.
// Ports:
//   sel_i    owner index
//   valid_i  per-master valid
//   data_i   packed master payloads, master i at [i*DW +: DW]
//   last_i   per-master last
//   valid_o / data_o / last_o  selected master's signals (zero if sel_i >= WIDTH)
module arb_payload_mux #(
  parameter int WIDTH = 5,
  parameter int BITW  = 3,
  parameter int DW    = 32
) (
  input  logic [BITW-1:0]     sel_i,
  input  logic [WIDTH-1:0]    valid_i,
  input  logic [WIDTH*DW-1:0] data_i,
  input  logic [WIDTH-1:0]    last_i,
  output logic                valid_o,
  output logic [DW-1:0]       data_o,
  output logic                last_o
);

  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    last_o  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_i == BITW'(i)) begin
        valid_o = valid_i[i];
        data_o  = data_i[i*DW +: DW];
        last_o  = last_i[i];
      end
    end
  end

endmodule

// File: rtl/arb_grant_mux.sv
// Grant consumer for the priority arbiter: forwards master requests to the
// arbiter while idle, locks the shared slave channel to the granted master for
// a whole burst, muxes that master's payload onto the slave port with a
// zero-latency valid/ready path, and releases ownership for one cycle after
// the last beat so the arbiter drops its grant.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   m_valid/m_data/m_last  master side inputs, m_ready per-master ready
//   arb_req           request vector to arbiter; arb_id = {valid, index}
//   s_valid/s_data/s_last/s_id  slave side outputs, s_ready slave ready
//   beat_cnt          beats accepted in current burst (saturating)
//   busy              channel owned (XFER or RELEASE)
//
// state   | meaning
// IDLE    | forward m_valid to arbiter, wait for a grant to a still-valid master
// XFER    | channel owned; payload of owner muxed to slave, beats counted
// RELEASE | one dead cycle with all requests low so the arbiter drops its grant
module arb_grant_mux
  import arb_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int BITW  = arb_log2(WIDTH),
  parameter int DW    = 32,
  parameter int CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    m_valid,
  input  logic [WIDTH*DW-1:0] m_data,
  input  logic [WIDTH-1:0]    m_last,
  output logic [WIDTH-1:0]    m_ready,
  output logic [WIDTH-1:0]    arb_req,
  input  logic [BITW:0]       arb_id,
  output logic                s_valid,
  output logic [DW-1:0]       s_data,
  output logic                s_last,
  output logic [BITW-1:0]     s_id,
  input  logic                s_ready,
  output logic [CNTW-1:0]     beat_cnt,
  output logic                busy
);

  arb_state_e      state_q, state_d;
  logic [BITW-1:0] owner_q, owner_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [BITW-1:0]  grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_oh;
  logic [WIDTH-1:0] owner_oh;
  logic             mux_valid;
  logic             mux_last;
  logic [DW-1:0]    mux_data;
  logic [WIDTH-1:0] req_raw;

  assign grant_vld = arb_id[BITW];
  assign grant_idx = arb_id[BITW-1:0];
  // Out-of-range indices decode to zero, so they can never match m_valid.
  assign grant_oh  = WIDTH'(arb_onehot(32'(grant_idx)));
  assign owner_oh  = WIDTH'(arb_onehot(32'(owner_q)));

  arb_payload_mux #(
    .WIDTH(WIDTH),
    .BITW (BITW),
    .DW   (DW)
  ) u_payload_mux (
    .sel_i  (owner_q),
    .valid_i(m_valid),
    .data_i (m_data),
    .last_i (m_last),
    .valid_o(mux_valid),
    .data_o (mux_data),
    .last_o (mux_last)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    req_raw = '0;
    m_ready = '0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_id    = '0;

    unique case (state_q)
      IDLE: begin
        req_raw = m_valid;
        // A grant to a master that has since withdrawn is dropped.
        if (grant_vld && |(grant_oh & m_valid)) begin
          owner_d = grant_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // Requesting only the owner keeps the arbiter's grant stable.
        req_raw = owner_oh;
        s_valid = mux_valid;
        s_data  = mux_data;
        s_last  = mux_last;
        s_id    = owner_q;
        m_ready = owner_oh & {WIDTH{s_ready}};
        if (mux_valid && s_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
          if (mux_last) state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset parks the FSM in IDLE, where requests would otherwise follow
  // m_valid; hold them low until reset is released.
  assign arb_req  = rst ? '0 : req_raw;
  assign beat_cnt = cnt_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_arb_grant_mux.sv
module tb_arb_grant_mux;
  localparam int WIDTH = 5;
  localparam int BITW  = 3;
  localparam int DW    = 32;
  localparam int CNTW  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH-1:0]    m_valid;
  logic [WIDTH*DW-1:0] m_data;
  logic [WIDTH-1:0]    m_last;
  logic [WIDTH-1:0]    m_ready;
  logic [WIDTH-1:0]    arb_req;
  logic [BITW:0]       arb_id;
  logic                s_valid;
  logic [DW-1:0]       s_data;
  logic                s_last;
  logic [BITW-1:0]     s_id;
  logic                s_ready;
  logic [CNTW-1:0]     beat_cnt;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  arb_grant_mux #(.WIDTH(WIDTH), .BITW(BITW), .DW(DW), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready),
    .arb_req (arb_req),
    .arb_id  (arb_id),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_id    (s_id),
    .s_ready (s_ready),
    .beat_cnt(beat_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pay(input int m, input int b);
    return DW'(32'hA000_0000 + m * 65536 + b);
  endfunction

  task automatic clear_inputs();
    m_valid = '0;
    m_data  = '0;
    m_last  = '0;
    arb_id  = '0;
    s_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst     = 1'b1;
    m_valid = 5'b10101;
    #2;
    checks++;
    if (arb_req !== 5'b0) begin
      failures++; $display("FAIL reset_arb_req: got %b expected %b", arb_req, 5'b0);
    end
    checks++;
    if ({m_ready, s_valid, s_last, s_id, busy, beat_cnt, s_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got m_ready=%b s_valid=%b s_last=%b s_id=%0d busy=%b beat_cnt=%0d s_data=%h expected all zero",
               m_ready, s_valid, s_last, s_id, busy, beat_cnt, s_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (arb_req !== 5'b10101 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_release_idle: got arb_req=%b busy=%b expected 10101/0", arb_req, busy);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_single_burst();
    @(negedge clk);
    m_valid = 5'b00100; arb_id = 4'b1010; s_ready = 1'b1;
    #1;
    checks++;
    if (arb_req !== 5'b00100 || busy !== 1'b0) begin
      failures++; $display("FAIL single_idle: got arb_req=%b busy=%b expected 00100/0", arb_req, busy);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      m_data[2*DW +: DW] = pay(2, b);
      m_last = (b == 3) ? 5'b00100 : 5'b0;
      #1;
      checks++;
      if (s_valid !== 1'b1 || s_id !== 3'd2 || s_data !== pay(2, b) || s_last !== (b == 3)) begin
        failures++;
        $display("FAIL single_beat%0d_slave: got v=%b id=%0d d=%h l=%b expected 1/2/%h/%b",
                 b, s_valid, s_id, s_data, s_last, pay(2, b), (b == 3));
      end
      checks++;
      if (m_ready !== 5'b00100 || arb_req !== 5'b00100 || beat_cnt !== CNTW'(b) || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_beat%0d_ctrl: got m_ready=%b arb_req=%b beat_cnt=%0d busy=%b expected 00100/00100/%0d/1",
                 b, m_ready, arb_req, beat_cnt, busy, b);
      end
    end
    @(negedge clk);
    m_valid = '0; m_last = '0;  // arb_id left stale on purpose
    #1;
    checks++;
    if (arb_req !== 5'b0 || s_valid !== 1'b0 || m_ready !== 5'b0 || busy !== 1'b1 || beat_cnt !== 8'd4) begin
      failures++;
      $display("FAIL single_release: got arb_req=%b s_valid=%b m_ready=%b busy=%b beat_cnt=%0d expected 0/0/0/1/4",
               arb_req, s_valid, m_ready, busy, beat_cnt);
    end
    @(negedge clk);
    arb_id = '0; m_valid = 5'b00011;
    #1;
    checks++;
    if (busy !== 1'b0 || arb_req !== 5'b00011 || beat_cnt !== 8'd4) begin
      failures++;
      $display("FAIL single_back_idle: got busy=%b arb_req=%b beat_cnt=%0d expected 0/00011/4", busy, arb_req, beat_cnt);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_contention();
    @(negedge clk);
    m_valid = 5'b01000; arb_id = 4'b1011; s_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      m_valid = 5'b01001;
      arb_id  = 4'b1000;
      m_data[3*DW +: DW] = pay(3, b);
      m_data[0*DW +: DW] = pay(0, 99);
      m_last  = (b == 2) ? 5'b01001 : 5'b00001;
      #1;
      checks++;
      if (s_id !== 3'd3 || arb_req !== 5'b01000 || m_ready !== 5'b01000 ||
          s_data !== pay(3, b) || s_last !== (b == 2)) begin
        failures++;
        $display("FAIL contend_beat%0d: got id=%0d arb_req=%b m_ready=%b d=%h l=%b expected 3/01000/01000/%h/%b",
                 b, s_id, arb_req, m_ready, s_data, s_last, pay(3, b), (b == 2));
      end
    end
    @(negedge clk);
    m_valid = 5'b00001; m_last = 5'b00001; m_data[0*DW +: DW] = pay(0, 7);
    #1;
    checks++;
    if (arb_req !== 5'b0 || busy !== 1'b1 || m_ready !== 5'b0) begin
      failures++; $display("FAIL contend_release: got arb_req=%b busy=%b m_ready=%b expected 0/1/0", arb_req, busy, m_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (arb_req !== 5'b00001 || busy !== 1'b0) begin
      failures++; $display("FAIL contend_idle_fwd: got arb_req=%b busy=%b expected 00001/0", arb_req, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_id !== 3'd0 || s_valid !== 1'b1 || s_last !== 1'b1 || s_data !== pay(0, 7) || beat_cnt !== 8'd0) begin
      failures++;
      $display("FAIL contend_m0_owns: got id=%0d v=%b l=%b d=%h cnt=%0d expected 0/1/1/%h/0",
               s_id, s_valid, s_last, s_data, beat_cnt, pay(0, 7));
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || beat_cnt !== 8'd1) begin
      failures++; $display("FAIL contend_end: got busy=%b cnt=%0d expected 0/1", busy, beat_cnt);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    m_valid = 5'b00010; arb_id = 4'b1001; s_ready = 1'b1;
    @(negedge clk);
    arb_id = '0;
    m_data[1*DW +: DW] = pay(1, 0);
    #1;
    checks++;
    if (m_ready !== 5'b00010 || beat_cnt !== 8'd0 || s_data !== pay(1, 0)) begin
      failures++; $display("FAIL bp_first: got m_ready=%b cnt=%0d d=%h expected 00010/0/%h", m_ready, beat_cnt, s_data, pay(1, 0));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_ready = 1'b0;
      m_data[1*DW +: DW] = pay(1, 1);
      #1;
      checks++;
      if (s_data !== pay(1, 1) || m_ready !== 5'b0 || beat_cnt !== 8'd1 || s_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall%0d: got d=%h m_ready=%b cnt=%0d v=%b expected %h/0/1/1", k, s_data, m_ready, beat_cnt, s_valid, pay(1, 1));
      end
    end
    @(negedge clk);
    s_ready = 1'b1; m_valid = 5'b10000;
    #1;
    checks++;
    if (s_valid !== 1'b0 || m_ready !== 5'b00010 || arb_req !== 5'b00010 || busy !== 1'b1 || beat_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bp_valid_drop: got v=%b m_ready=%b arb_req=%b busy=%b cnt=%0d expected 0/00010/00010/1/1",
               s_valid, m_ready, arb_req, busy, beat_cnt);
    end
    @(negedge clk);
    m_valid = 5'b00010; m_last = 5'b00010;
    #1;
    checks++;
    if (beat_cnt !== 8'd1 || m_ready !== 5'b00010 || s_last !== 1'b1 || s_data !== pay(1, 1)) begin
      failures++; $display("FAIL bp_resume: got cnt=%0d m_ready=%b l=%b d=%h expected 1/00010/1/%h", beat_cnt, m_ready, s_last, s_data, pay(1, 1));
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (beat_cnt !== 8'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL bp_release: got cnt=%0d busy=%b expected 2/1", beat_cnt, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_withdrawn();
    @(negedge clk);
    m_valid = 5'b00100; arb_id = 4'b1001;
    #1;
    checks++;
    if (arb_req !== 5'b00100) begin
      failures++; $display("FAIL wd_req: got %b expected 00100", arb_req);
    end
    @(negedge clk);
    m_valid = 5'b11111; arb_id = 4'b1110;
    #1;
    checks++;
    if (busy !== 1'b0 || m_ready !== 5'b0 || s_valid !== 1'b0) begin
      failures++; $display("FAIL wd_withdrawn: got busy=%b m_ready=%b v=%b expected 0/0/0", busy, m_ready, s_valid);
    end
    @(negedge clk);
    m_valid = 5'b01000; arb_id = 4'b0011;
    #1;
    checks++;
    if (busy !== 1'b0 || m_ready !== 5'b0) begin
      failures++; $display("FAIL wd_out_of_range: got busy=%b m_ready=%b expected 0/0", busy, m_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || arb_req !== 5'b01000) begin
      failures++; $display("FAIL wd_invalid_id: got busy=%b arb_req=%b expected 0/01000", busy, arb_req);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    m_valid = 5'b10000; arb_id = 4'b1100; s_ready = 1'b1;
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      arb_id = '0;
      #1;
      checks++;
      if (beat_cnt !== CNTW'((k > 255) ? 255 : k)) begin
        failures++; $display("FAIL sat_cnt%0d: got %0d expected %0d", k, beat_cnt, (k > 255) ? 255 : k);
      end
    end
    @(negedge clk);
    m_last = 5'b10000;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (beat_cnt !== 8'd255 || busy !== 1'b1) begin
      failures++; $display("FAIL sat_release: got cnt=%0d busy=%b expected 255/1", beat_cnt, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    m_valid = 5'b00100; arb_id = 4'b1010; s_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      m_data[2*DW +: DW] = pay(2, b);
    end
    @(negedge clk);
    #1;
    checks++;
    if (beat_cnt !== 8'd3 || busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: got cnt=%0d busy=%b expected 3/1", beat_cnt, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || s_valid !== 1'b0 || m_ready !== 5'b0 || beat_cnt !== 8'd0 || arb_req !== 5'b0) begin
      failures++;
      $display("FAIL rstmid_same_cycle: got busy=%b v=%b m_ready=%b cnt=%0d arb_req=%b expected 0/0/0/0/0",
               busy, s_valid, m_ready, beat_cnt, arb_req);
    end
    arb_id = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (arb_req !== 5'b00100 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_after: got arb_req=%b busy=%b expected 00100/0", arb_req, busy);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Reference model: channel either free, owned by a master, or in its
  // post-burst dead cycle; outputs derived from that ownership view.
  task automatic test_random(input int ncyc);
    int  owner;
    bit  draining;
    int  cnt;
    int  idx;
    logic [WIDTH-1:0] e_req, e_rdy;
    logic             e_v, e_l, e_busy;
    logic [DW-1:0]    e_d;
    logic [BITW-1:0]  e_id;
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    owner = -1; draining = 1'b0; cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      m_valid = WIDTH'($urandom_range(0, 31));
      for (int i = 0; i < WIDTH; i++) begin
        m_last[i] = ($urandom_range(0, 3) == 0);
        m_data[i*DW +: DW] = $urandom;
      end
      arb_id  = {($urandom_range(0, 3) != 0), BITW'($urandom_range(0, 7))};
      s_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_req = '0; e_rdy = '0; e_v = 1'b0; e_l = 1'b0; e_d = '0; e_id = '0;
      e_busy = draining || (owner >= 0);
      if (!draining && owner < 0) begin
        e_req = m_valid;
      end else if (!draining) begin
        e_req = WIDTH'(1 << owner);
        e_v   = m_valid[owner];
        e_l   = m_last[owner];
        e_d   = m_data[owner*DW +: DW];
        e_id  = BITW'(owner);
        e_rdy = s_ready ? WIDTH'(1 << owner) : '0;
      end
      checks++;
      if (arb_req !== e_req || m_ready !== e_rdy) begin
        failures++; $display("FAIL rand%0d_req_rdy: got %b/%b expected %b/%b", c, arb_req, m_ready, e_req, e_rdy);
      end
      checks++;
      if (s_valid !== e_v || s_last !== e_l || s_data !== e_d || s_id !== e_id) begin
        failures++;
        $display("FAIL rand%0d_slave: got v=%b l=%b d=%h id=%0d expected %b/%b/%h/%0d", c, s_valid, s_last, s_data, s_id, e_v, e_l, e_d, e_id);
      end
      checks++;
      if (busy !== e_busy || beat_cnt !== CNTW'(cnt)) begin
        failures++; $display("FAIL rand%0d_state: got busy=%b cnt=%0d expected %b/%0d", c, busy, beat_cnt, e_busy, cnt);
      end
      if (draining) begin
        draining = 1'b0;
      end else if (owner >= 0) begin
        if (m_valid[owner] && s_ready) begin
          if (cnt < 255) cnt++;
          if (m_last[owner]) begin
            owner = -1;
            draining = 1'b1;
          end
        end
      end else begin
        idx = int'(arb_id[BITW-1:0]);
        if (arb_id[BITW] && idx < WIDTH && m_valid[idx]) begin
          owner = idx;
          cnt = 0;
        end
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_withdrawn();
    test_saturation();
    test_reset_midburst();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
